efuse_seq_ctrl: RTL and testbench

EFUSE_SEQ_CTRL -- requirements
Module: efuse_seq_ctrl

---
 rtl/efuse_seq_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_efuse_seq_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/efuse_seq_ctrl.sv
// eFuse macro sequencer: read and program cycles with PSM power-up/down and a valid/ready request/response handshake.
// Fuse programming is compiled in only when EFUSE_SEQ_CTRL_PROG_EN is defined.
module efuse_seq_ctrl #(
  parameter int EFUSE_ADDR_W   = 14,
  parameter int EFUSE_NUM_ADDR = 10240,
  parameter int SETUP_CYC      = 2,
  parameter int RD_STROBE_CYC  = 4,
  parameter int PG_STROBE_CYC  = 200,
  parameter int HOLD_CYC       = 2,
  parameter int PSM_SETTLE_CYC = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic                    i_req_prog,
  input  logic [EFUSE_ADDR_W-1:0] i_req_addr,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [39:0]             o_rsp_data,
  output logic                    o_rsp_err,
  output logic                    o_busy,
  output logic                    o_efuse_csb,
  output logic                    o_efuse_strobe,
  output logic                    o_efuse_load,
  output logic                    o_efuse_pgenb,
  output logic                    o_efuse_psm,
  output logic [EFUSE_ADDR_W-1:0] o_efuse_a,
  output logic                    o_efuse_te,
  output logic [2:0]              o_efuse_ts,
  output logic [1:0]              o_efuse_pmr,
  output logic                    o_efuse_vddrdy,
  input  logic [39:0]             i_efuse_q,
  input  logic [1:0]              i_efuse_qt
);

  // state   | meaning
  // IDLE    | waiting for a request, o_req_ready=1
  // PSM_ON  | program supply ramp before the macro is selected
  // SETUP   | csb low, address and mode settled before strobe
  // STROBE  | strobe high (read sense or program pulse)
  // HOLD    | strobe low, csb still low
  // PSM_OFF | program supply ramp-down, macro deselected
  // RSP     | response presented until accepted
  typedef enum logic [2:0] {
    IDLE, PSM_ON, SETUP, STROBE, HOLD, PSM_OFF, RSP
  } state_t;

  localparam logic [31:0] NUM_ADDR = 32'(EFUSE_NUM_ADDR);

  state_t                  state, state_nx;
  logic [15:0]             cnt, cnt_load, strobe_len;
  logic [EFUSE_ADDR_W-1:0] addr_q;
  logic                    accept, addr_bad, req_err, last_rd_strobe;
  logic                    csb_nx, strobe_nx, load_nx, pgenb_nx, psm_nx, rsp_valid_nx;
  logic [EFUSE_ADDR_W-1:0] a_nx;
  logic                    unused_qt;

  assign unused_qt      = ^i_efuse_qt;
  assign o_efuse_te     = 1'b0;
  assign o_efuse_ts     = 3'b000;
  assign o_efuse_pmr    = 2'b00;
  assign o_efuse_vddrdy = 1'b0;

  assign o_req_ready = (state == IDLE);
  assign o_busy      = (state != IDLE);
  assign accept      = i_req_valid && (state == IDLE);
  assign addr_bad    = 32'(i_req_addr) >= NUM_ADDR;

`ifdef EFUSE_SEQ_CTRL_PROG_EN
  logic prog_q;
  assign req_err        = addr_bad;
  assign strobe_len     = prog_q ? 16'(PG_STROBE_CYC - 1) : 16'(RD_STROBE_CYC - 1);
  assign last_rd_strobe = (state == STROBE) && (cnt == '0) && !prog_q;
`else
  // without programming support any program request is rejected up front
  assign req_err        = addr_bad || i_req_prog;
  assign strobe_len     = 16'(RD_STROBE_CYC - 1);
  assign last_rd_strobe = (state == STROBE) && (cnt == '0);
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state_nx != state) begin
        cnt <= cnt_load;
      end else if (cnt != '0) begin
        cnt <= cnt - 16'd1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err) state_nx = RSP;
`ifdef EFUSE_SEQ_CTRL_PROG_EN
          else if (i_req_prog) state_nx = PSM_ON;
`endif
          else state_nx = SETUP;
        end
      end
`ifdef EFUSE_SEQ_CTRL_PROG_EN
      PSM_ON:  if (cnt == '0) state_nx = SETUP;
      PSM_OFF: if (cnt == '0) state_nx = RSP;
      HOLD:    if (cnt == '0) state_nx = prog_q ? PSM_OFF : RSP;
`else
      HOLD:    if (cnt == '0) state_nx = RSP;
`endif
      SETUP:   if (cnt == '0) state_nx = STROBE;
      STROBE:  if (cnt == '0) state_nx = HOLD;
      RSP:     if (o_rsp_valid && i_rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cnt_load = '0;
    case (state_nx)
`ifdef EFUSE_SEQ_CTRL_PROG_EN
      PSM_ON, PSM_OFF: cnt_load = 16'(PSM_SETTLE_CYC - 1);
`endif
      SETUP:   cnt_load = 16'(SETUP_CYC - 1);
      STROBE:  cnt_load = strobe_len;
      HOLD:    cnt_load = 16'(HOLD_CYC - 1);
      default: cnt_load = '0;
    endcase
  end

  // Macro pins are registered decodes of the current state, so every pin
  // changes on the same edge and none can glitch.
  always_comb begin
    csb_nx       = !((state == SETUP) || (state == STROBE) || (state == HOLD));
    strobe_nx    = (state == STROBE);
    a_nx         = csb_nx ? '0 : addr_q;
    load_nx      = 1'b1;
    pgenb_nx     = 1'b1;
    psm_nx       = 1'b0;
    rsp_valid_nx = (state == RSP) && !(o_rsp_valid && i_rsp_ready);
`ifdef EFUSE_SEQ_CTRL_PROG_EN
    if (prog_q) begin
      psm_nx   = (state == PSM_ON) || !csb_nx;
      load_nx  = csb_nx;
      pgenb_nx = csb_nx;
    end
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_efuse_csb    <= 1'b1;
      o_efuse_strobe <= 1'b0;
      o_efuse_load   <= 1'b1;
      o_efuse_pgenb  <= 1'b1;
      o_efuse_psm    <= 1'b0;
      o_efuse_a      <= '0;
      o_rsp_valid    <= 1'b0;
    end else begin
      o_efuse_csb    <= csb_nx;
      o_efuse_strobe <= strobe_nx;
      o_efuse_load   <= load_nx;
      o_efuse_pgenb  <= pgenb_nx;
      o_efuse_psm    <= psm_nx;
      o_efuse_a      <= a_nx;
      o_rsp_valid    <= rsp_valid_nx;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_q     <= '0;
      o_rsp_data <= '0;
      o_rsp_err  <= 1'b0;
    end else if (accept) begin
      addr_q     <= i_req_addr;
      o_rsp_data <= '0;
      o_rsp_err  <= req_err;
    end else if (last_rd_strobe) begin
      o_rsp_data <= i_efuse_q;
    end
  end

`ifdef EFUSE_SEQ_CTRL_PROG_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prog_q <= 1'b0;
    end else if (accept) begin
      prog_q <= i_req_prog;
    end
  end
`endif

endmodule

// File: tb/tb_efuse_seq_ctrl.sv
// Directed plus randomized checks of efuse_seq_ctrl against a cycle-count model of the sequencing rules.
module tb_efuse_seq_ctrl;
  localparam int AW  = 14;
  localparam int NUM = 10240;
  localparam int SU  = 2;
  localparam int RD  = 4;
  localparam int PG  = 200;
  localparam int HD  = 2;
  localparam int PS  = 16;
`ifdef EFUSE_SEQ_CTRL_PROG_EN
  localparam bit PROG_EN = 1'b1;
`else
  localparam bit PROG_EN = 1'b0;
`endif

  logic          i_clk, i_rst_n;
  logic          i_req_valid, o_req_ready, i_req_prog;
  logic [AW-1:0] i_req_addr;
  logic          o_rsp_valid, i_rsp_ready;
  logic [39:0]   o_rsp_data;
  logic          o_rsp_err, o_busy;
  logic          o_efuse_csb, o_efuse_strobe, o_efuse_load, o_efuse_pgenb, o_efuse_psm;
  logic [AW-1:0] o_efuse_a;
  logic          o_efuse_te;
  logic [2:0]    o_efuse_ts;
  logic [1:0]    o_efuse_pmr;
  logic          o_efuse_vddrdy;
  logic [39:0]   i_efuse_q;
  logic [1:0]    i_efuse_qt;

  logic [39:0] fuse_mem [0:NUM-1];
  int n_assert = 0;
  int n_fail   = 0;

  efuse_seq_ctrl dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_prog(i_req_prog), .i_req_addr(i_req_addr),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err), .o_busy(o_busy),
    .o_efuse_csb(o_efuse_csb), .o_efuse_strobe(o_efuse_strobe),
    .o_efuse_load(o_efuse_load), .o_efuse_pgenb(o_efuse_pgenb),
    .o_efuse_psm(o_efuse_psm), .o_efuse_a(o_efuse_a),
    .o_efuse_te(o_efuse_te), .o_efuse_ts(o_efuse_ts),
    .o_efuse_pmr(o_efuse_pmr), .o_efuse_vddrdy(o_efuse_vddrdy),
    .i_efuse_q(i_efuse_q), .i_efuse_qt(i_efuse_qt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // fuse array model: the macro returns the word at the presented address
  always_comb begin
    i_efuse_q = '0;
    if (int'(o_efuse_a) < NUM) i_efuse_q = fuse_mem[int'(o_efuse_a)];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input bit prog, input int addr, input int stall);
    bit ok;
    int lat_exp, strb_exp, csb_exp, psm_exp, pg_exp;
    logic [39:0] data_exp;
    int lat, strb, csb_lo, psm_hi, pg_lo, ld_lo, a_bad, busy_bad;
    int psm_rise, csb_fall, psm_fall;
    bit done;
    ok       = (addr < NUM) && (!prog || PROG_EN);
    lat_exp  = !ok ? 1 : (prog ? 1 + PS + SU + PG + HD + PS : 1 + SU + RD + HD);
    strb_exp = ok ? (prog ? PG : RD) : 0;
    csb_exp  = ok ? SU + (prog ? PG : RD) + HD : 0;
    psm_exp  = (ok && prog) ? PS + SU + PG + HD : 0;
    pg_exp   = (ok && prog) ? SU + PG + HD : 0;
    data_exp = (ok && !prog) ? fuse_mem[addr] : 40'h0;
    lat = 0; strb = 0; csb_lo = 0; psm_hi = 0; pg_lo = 0; ld_lo = 0;
    a_bad = 0; busy_bad = 0; psm_rise = -1; csb_fall = -1; psm_fall = -1; done = 0;

    chk("req_ready_idle", o_req_ready, 1'b1);
    i_req_valid = 1'b1;
    i_req_prog  = prog;
    i_req_addr  = AW'(addr);
    i_rsp_ready = (stall == 0);
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    i_req_prog  = 1'($urandom);
    i_req_addr  = AW'($urandom);
    while (!done && lat < lat_exp + 20) begin
      @(posedge i_clk); #1;
      lat++;
      if (o_efuse_strobe) strb++;
      if (!o_efuse_load) ld_lo++;
      if (!o_efuse_pgenb) pg_lo++;
      if (!o_busy) busy_bad++;
      if (!o_efuse_csb) begin
        csb_lo++;
        if (csb_fall < 0) csb_fall = lat;
        if (o_efuse_a !== AW'(addr)) a_bad++;
      end
      if (o_efuse_psm) begin
        psm_hi++;
        if (psm_rise < 0) psm_rise = lat;
      end else if (psm_rise >= 0 && psm_fall < 0) begin
        psm_fall = lat;
      end
      if (o_rsp_valid) done = 1;
    end
    chk("rsp_valid_seen", o_rsp_valid, 1'b1);
    chk("rsp_latency", lat, lat_exp);
    chk("rsp_err", o_rsp_err, !ok);
    chk("rsp_data", o_rsp_data, data_exp);
    chk("strobe_cycles", strb, strb_exp);
    chk("csb_low_cycles", csb_lo, csb_exp);
    chk("psm_high_cycles", psm_hi, psm_exp);
    chk("pgenb_low_cycles", pg_lo, pg_exp);
    chk("load_low_cycles", ld_lo, pg_exp);
    chk("addr_stable", a_bad, 0);
    chk("busy_during_op", busy_bad, 0);
    chk("psm_lead", (psm_exp > 0) ? csb_fall - psm_rise : psm_rise, (psm_exp > 0) ? PS : -1);
    chk("psm_trail", (psm_exp > 0) ? lat - psm_fall : psm_fall, (psm_exp > 0) ? PS : -1);
    for (int i = 0; i < stall; i++) begin
      @(posedge i_clk); #1;
      chk("stall_valid", o_rsp_valid, 1'b1);
      chk("stall_data", o_rsp_data, data_exp);
      chk("stall_req_ready", o_req_ready, 1'b0);
    end
    i_rsp_ready = 1'b1;
    @(posedge i_clk); #1;
    chk("valid_after_hs", o_rsp_valid, 1'b0);
    chk("ready_after_hs", o_req_ready, 1'b1);
  endtask

  initial begin
    bit rprog;
    int raddr, target, strb, guard, rsp_seen, nready;
    i_rst_n     = 1'b0;
    i_req_valid = 1'b0;
    i_req_prog  = 1'b0;
    i_req_addr  = '0;
    i_rsp_ready = 1'b1;
    i_efuse_qt  = 2'b00;
    for (int i = 0; i < NUM; i++) fuse_mem[i] = {8'($urandom), 32'($urandom)};
    fuse_mem[5] = 40'hA5_1234_5678;
    #12;
    chk("rst_csb", o_efuse_csb, 1'b1);
    chk("rst_strobe", o_efuse_strobe, 1'b0);
    chk("rst_load", o_efuse_load, 1'b1);
    chk("rst_pgenb", o_efuse_pgenb, 1'b1);
    chk("rst_psm", o_efuse_psm, 1'b0);
    chk("rst_a", o_efuse_a, '0);
    chk("rst_rsp_valid", o_rsp_valid, 1'b0);
    chk("rst_rsp_data", o_rsp_data, '0);
    chk("rst_rsp_err", o_rsp_err, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("tie_offs", {o_efuse_te, o_efuse_ts, o_efuse_pmr, o_efuse_vddrdy}, '0);
    repeat (3) @(posedge i_clk);
    @(negedge i_clk) i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    chk("ready_after_rst", o_req_ready, 1'b1);

    run_op(1'b0, 5, 0);
    run_op(1'b0, NUM, 0);
    run_op(1'b1, 'h1FFF, 0);
    run_op(1'b1, 1, 0);
    run_op(1'b0, 9, 5);
    run_op(1'b0, NUM - 1, 0);
    run_op(1'b0, 0, 1);
    for (int k = 0; k < 16; k++) begin
      rprog = ($urandom_range(0, 3) == 0);
      raddr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(NUM, 16383))
                                          : int'($urandom_range(0, NUM - 1));
      run_op(rprog, raddr, int'($urandom_range(0, 3)));
    end

    // abort mid-strobe: program pulse when programming exists, else a read
    rprog  = PROG_EN;
    target = rprog ? 50 : 2;
    strb = 0; guard = 0;
    i_req_valid = 1'b1;
    i_req_prog  = rprog;
    i_req_addr  = AW'(3);
    i_rsp_ready = 1'b1;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    while (strb < target && guard < 400) begin
      @(posedge i_clk); #1;
      guard++;
      if (o_efuse_strobe) strb++;
    end
    chk("abort_strobe_reached", strb, target);
    #2 i_rst_n = 1'b0;
    #1;
    chk("abort_strobe", o_efuse_strobe, 1'b0);
    chk("abort_psm", o_efuse_psm, 1'b0);
    chk("abort_csb", o_efuse_csb, 1'b1);
    chk("abort_pgenb", o_efuse_pgenb, 1'b1);
    chk("abort_busy", o_busy, 1'b0);
    @(negedge i_clk) i_rst_n = 1'b1;
    rsp_seen = 0; nready = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge i_clk); #1;
      if (o_rsp_valid) rsp_seen++;
      if (!o_req_ready) nready++;
    end
    chk("abort_no_rsp", rsp_seen, 0);
    chk("abort_req_ready", nready, 0);
    chk("abort_csb_idle", o_efuse_csb, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
